// File: rtl/mqnic_l2_ingress_mac_ctrl.sv
// L2 ingress stage: zero-latency pass-through that strips MAC control frames
// (EtherType 0x8808), applies PAUSE quanta to a timer and keeps drop statistics.
module mqnic_l2_ingress_mac_ctrl #(
   parameter int AXIS_DATA_WIDTH     = 256,
   parameter int AXIS_KEEP_WIDTH     = AXIS_DATA_WIDTH/8,
   parameter int AXIS_USER_WIDTH     = 1,
   parameter int AXIS_USE_READY      = 0,
   parameter int PAUSE_QUANTA_CYCLES = 2,
   parameter int STAT_WIDTH          = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tlast,
   input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
   input  logic                       cfg_ctrl_filter_enable,
   output logic                       pause_active,
   output logic [15:0]                pause_quanta_remaining,
   output logic [STAT_WIDTH-1:0]      stat_rx_ctrl_frames,
   output logic [STAT_WIDTH-1:0]      stat_rx_pause_frames
);

   typedef enum logic [1:0] {ST_SOF, ST_PASS, ST_DROP} state_t;

   localparam logic [7:0] PRESC_LAST = 8'(PAUSE_QUANTA_CYCLES - 1);

   state_t state, state_nxt;

   logic [15:0] ethertype, opcode, quanta;
   logic        is_ctrl, drop_now, xfer;
   logic        is_pause_q, pause_eff, ctrl_end, pause_load;
   logic [15:0] quanta_q, quanta_eff;
   logic [15:0] timer, timer_nxt;
   logic [7:0]  presc, presc_nxt;
   logic        pause_active_q;
   logic [STAT_WIDTH-1:0] ctrl_cnt, pause_cnt;

   // Header is big-endian and always fits in the first beat.
   assign ethertype = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
   assign opcode    = {s_axis_tdata[14*8 +: 8], s_axis_tdata[15*8 +: 8]};
   assign quanta    = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};

   assign is_ctrl  = cfg_ctrl_filter_enable && (ethertype == 16'h8808);
   assign drop_now = ((state == ST_SOF) && is_ctrl) || (state == ST_DROP);

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tlast  = s_axis_tlast;
   assign m_axis_tuser  = s_axis_tuser;
   assign m_axis_tvalid = s_axis_tvalid && !drop_now;
   assign s_axis_tready = (AXIS_USE_READY != 0) ? (drop_now || m_axis_tready) : 1'b1;
   assign xfer          = s_axis_tvalid && s_axis_tready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_SOF;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (xfer) begin
         case (state)
            ST_SOF:  if (!s_axis_tlast) state_nxt = is_ctrl ? ST_DROP : ST_PASS;
            ST_PASS,
            ST_DROP: if (s_axis_tlast) state_nxt = ST_SOF;
            default: state_nxt = ST_SOF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_pause_q <= 1'b0;
         quanta_q   <= 16'd0;
      end else if (xfer && (state == ST_SOF) && is_ctrl) begin
         is_pause_q <= (opcode == 16'h0001);
         quanta_q   <= quanta;
      end
   end

   // Single-beat control frames must use the live header, not the latch.
   assign pause_eff  = (state == ST_SOF) ? (opcode == 16'h0001) : is_pause_q;
   assign quanta_eff = (state == ST_SOF) ? quanta : quanta_q;
   assign ctrl_end   = xfer && drop_now && s_axis_tlast;
   assign pause_load = ctrl_end && pause_eff && !s_axis_tuser[0];

   always_comb begin
      timer_nxt = timer;
      presc_nxt = presc;
      if (pause_load) begin
         timer_nxt = quanta_eff;
         presc_nxt = 8'd0;
      end else if (timer != 16'd0) begin
         if (presc == PRESC_LAST) begin
            presc_nxt = 8'd0;
            timer_nxt = timer - 16'd1;
         end else begin
            presc_nxt = presc + 8'd1;
         end
      end
   end

   // pause_active is registered from the next timer value so it tracks the timer exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer          <= 16'd0;
         presc          <= 8'd0;
         pause_active_q <= 1'b0;
      end else begin
         timer          <= timer_nxt;
         presc          <= presc_nxt;
         pause_active_q <= (timer_nxt != 16'd0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_cnt  <= '0;
         pause_cnt <= '0;
      end else begin
         if (ctrl_end)   ctrl_cnt  <= ctrl_cnt + 1'b1;
         if (pause_load) pause_cnt <= pause_cnt + 1'b1;
      end
   end

   assign pause_active           = pause_active_q;
   assign pause_quanta_remaining = timer;
   assign stat_rx_ctrl_frames    = ctrl_cnt;
   assign stat_rx_pause_frames   = pause_cnt;

endmodule

// File: tb/tb_mqnic_l2_ingress_mac_ctrl.sv
// Scoreboard bench: the driver queues expected forwarded beats, a negedge monitor pops and compares.
module tb_mqnic_l2_ingress_mac_ctrl;

   localparam int DW = 256;
   localparam int KW = DW/8;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic [KW-1:0] s_axis_tkeep = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [0:0]    s_axis_tuser = '0;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic [0:0]    m_axis_tuser;
   logic          cfg_ctrl_filter_enable = 1'b1;
   logic          pause_active;
   logic [15:0]   pause_quanta_remaining;
   logic [31:0]   stat_rx_ctrl_frames;
   logic [31:0]   stat_rx_pause_frames;

   int    checks = 0;
   int    errors = 0;
   logic  tog_en = 1'b0;
   beat_t exp_q[$];

   mqnic_l2_ingress_mac_ctrl #(
      .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(1),
      .AXIS_USE_READY(1), .PAUSE_QUANTA_CYCLES(2), .STAT_WIDTH(32)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .cfg_ctrl_filter_enable(cfg_ctrl_filter_enable),
      .pause_active(pause_active), .pause_quanta_remaining(pause_quanta_remaining),
      .stat_rx_ctrl_frames(stat_rx_ctrl_frames), .stat_rx_pause_frames(stat_rx_pause_frames)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] hdr(input logic [15:0] et, input logic [15:0] op,
                                         input logic [15:0] qn, input logic [7:0] seed);
      logic [DW-1:0] d;
      for (int i = 0; i < KW; i++) d[i*8 +: 8] = seed + 8'(i);
      d[12*8 +: 8] = et[15:8];
      d[13*8 +: 8] = et[7:0];
      d[14*8 +: 8] = op[15:8];
      d[15*8 +: 8] = op[7:0];
      d[16*8 +: 8] = qn[15:8];
      d[17*8 +: 8] = qn[7:0];
      return d;
   endfunction

   // fwd=1: beat must appear on m_axis; fwd=0: beat must be swallowed in one cycle.
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l, input logic u, input logic fwd);
      int   n = 0;
      logic acc = 1'b0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tuser  = u;
      s_axis_tvalid = 1'b1;
      if (fwd) exp_q.push_back('{d, k, l, u});
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = s_axis_tready;
         if (!fwd) begin
            if (n == 0) chk("drop_ready", {63'd0, s_axis_tready}, 64'd1);
            chk("drop_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
         end
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("beat_timeout", 64'd0, 64'd1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic chk_stats(input string nm, input int c, input int p);
      chk({nm, "_ctrl"}, 64'(stat_rx_ctrl_frames), 64'(c));
      chk({nm, "_pause"}, 64'(stat_rx_pause_frames), 64'(p));
   endtask

   // Monitor: every accepted output beat must match the head of the queue.
   always @(negedge clk) begin
      if (rst && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("out_data", 64'(m_axis_tdata[127:0] ^ m_axis_tdata[255:128]),
                64'(e.data[127:0] ^ e.data[255:128]));
            chk("out_data_hdr", 64'(m_axis_tdata[143:80]), 64'(e.data[143:80]));
            chk("out_keep", 64'(m_axis_tkeep), 64'(e.keep));
            chk("out_last_user", {62'd0, m_axis_tlast, m_axis_tuser[0]}, {62'd0, e.last, e.user});
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) m_axis_tready = ~m_axis_tready;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [KW-1:0] kf;
      logic [KW-1:0] kp;
      kf = '1;
      kp = 32'h0000_FFFF;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      chk("rst_pause", {63'd0, pause_active}, 64'd0);
      chk("rst_remaining", 64'(pause_quanta_remaining), 64'd0);
      chk_stats("rst", 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Normal IPv4 frame; 0x8808 in a later beat must be ignored
      send_beat(hdr(16'h0800, 16'h4500, 16'h0054, 8'h10), kf, 1'b0, 1'b0, 1'b1);
      send_beat(hdr(16'h8808, 16'h0001, 16'h0009, 8'h40), kf, 1'b0, 1'b0, 1'b1);
      send_beat(hdr(16'h1234, 16'h5678, 16'h9abc, 8'h70), kp, 1'b1, 1'b0, 1'b1);
      chk_stats("normal", 0, 0);
      chk("normal_pause", {63'd0, pause_active}, 64'd0);

      // PAUSE quanta 3: 3 quanta * 2 cycles = 6 cycles
      send_beat(hdr(16'h8808, 16'h0001, 16'h0003, 8'h20), kf, 1'b0, 1'b0, 1'b0);
      send_beat(hdr(16'h0000, 16'h0000, 16'h0000, 8'h30), kp, 1'b1, 1'b0, 1'b0);
      chk("pause3_active", {63'd0, pause_active}, 64'd1);
      chk("pause3_rem", 64'(pause_quanta_remaining), 64'd3);
      chk_stats("pause3", 1, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("pause3_rem_5", 64'(pause_quanta_remaining), 64'd1);
      chk("pause3_active_5", {63'd0, pause_active}, 64'd1);
      @(posedge clk);
      #1;
      chk("pause3_rem_6", 64'(pause_quanta_remaining), 64'd0);
      chk("pause3_active_6", {63'd0, pause_active}, 64'd0);

      // Bad PAUSE frame: counted as control, not applied
      send_beat(hdr(16'h8808, 16'h0001, 16'h0003, 8'h21), kf, 1'b0, 1'b0, 1'b0);
      send_beat(hdr(16'h0000, 16'h0000, 16'h0000, 8'h31), kp, 1'b1, 1'b1, 1'b0);
      chk_stats("bad", 2, 1);
      chk("bad_active", {63'd0, pause_active}, 64'd0);

      // Reload: quanta 100, 20 cycles later quanta 0
      send_beat(hdr(16'h8808, 16'h0001, 16'd100, 8'h22), kf, 1'b0, 1'b0, 1'b0);
      send_beat(hdr(16'h0000, 16'h0000, 16'h0000, 8'h32), kp, 1'b1, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      chk("reload_rem_20", 64'(pause_quanta_remaining), 64'd90);
      chk("reload_active_20", {63'd0, pause_active}, 64'd1);
      send_beat(hdr(16'h8808, 16'h0001, 16'h0000, 8'h23), kf, 1'b0, 1'b0, 1'b0);
      send_beat(hdr(16'h0000, 16'h0000, 16'h0000, 8'h33), kp, 1'b1, 1'b0, 1'b0);
      chk("reload_active_0", {63'd0, pause_active}, 64'd0);
      chk("reload_rem_0", 64'(pause_quanta_remaining), 64'd0);
      chk_stats("reload", 4, 3);

      // Single-beat PAUSE uses same-beat header
      send_beat(hdr(16'h8808, 16'h0001, 16'h0001, 8'h24), kp, 1'b1, 1'b0, 1'b0);
      chk("single_rem", 64'(pause_quanta_remaining), 64'd1);
      chk_stats("single", 5, 4);
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: tready toggling, normal frame then non-PAUSE control frame
      tog_en = 1'b1;
      send_beat(hdr(16'h0800, 16'h4500, 16'h0040, 8'h50), kf, 1'b0, 1'b0, 1'b1);
      send_beat(hdr(16'h0800, 16'h0000, 16'h0000, 8'h60), kf, 1'b0, 1'b0, 1'b1);
      send_beat(hdr(16'h0800, 16'h0000, 16'h0000, 8'h68), kp, 1'b1, 1'b1, 1'b1);
      send_beat(hdr(16'h8808, 16'h0101, 16'h0007, 8'h25), kf, 1'b0, 1'b0, 1'b0);
      cfg_ctrl_filter_enable = 1'b0;
      send_beat(hdr(16'h0000, 16'h0000, 16'h0000, 8'h35), kp, 1'b1, 1'b0, 1'b0);
      cfg_ctrl_filter_enable = 1'b1;
      tog_en = 1'b0;
      m_axis_tready = 1'b1;
      chk_stats("bp", 6, 4);
      chk("bp_active", {63'd0, pause_active}, 64'd0);

      // Filter disabled: PAUSE frame forwarded untouched
      cfg_ctrl_filter_enable = 1'b0;
      send_beat(hdr(16'h8808, 16'h0001, 16'h0005, 8'h26), kf, 1'b0, 1'b0, 1'b1);
      send_beat(hdr(16'h0000, 16'h0000, 16'h0000, 8'h36), kp, 1'b1, 1'b0, 1'b1);
      chk_stats("nofilt", 6, 4);
      chk("nofilt_active", {63'd0, pause_active}, 64'd0);
      cfg_ctrl_filter_enable = 1'b1;

      // Reset mid-frame while paused
      send_beat(hdr(16'h8808, 16'h0001, 16'd50, 8'h27), kp, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_active", {63'd0, pause_active}, 64'd1);
      send_beat(hdr(16'h0800, 16'h0000, 16'h0000, 8'h77), kf, 1'b0, 1'b0, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      chk("mid_rst_active", {63'd0, pause_active}, 64'd0);
      chk("mid_rst_rem", 64'(pause_quanta_remaining), 64'd0);
      chk_stats("mid_rst", 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      // FSM is back in SOF: a control first beat is recognised
      send_beat(hdr(16'h8808, 16'h0001, 16'h0002, 8'h28), kp, 1'b1, 1'b0, 1'b0);
      chk("post_rst_rem", 64'(pause_quanta_remaining), 64'd2);
      chk_stats("post_rst", 1, 1);

      repeat (4) @(posedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mqnic_l2_ingress_mac_ctrl.md
Name: mqnic_l2_ingress_mac_ctrl

Overview:
Layer 2 ingress stage between the MAC RX stream and the internal datapath. It forwards normal frames with zero latency. It detects IEEE 802.3 MAC control frames (EtherType 0x8808) and removes them from the stream. For valid PAUSE frames (opcode 0x0001) it runs a pause timer and exports pause state to the TX scheduler, and it keeps wrapping statistics counters.

Parameters:
AXIS_DATA_WIDTH, 256, stream width in bits; legal values 256 or 512, so the full header (bytes 0..17) always arrives in the first beat.
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
AXIS_USER_WIDTH, 1, tuser width; bit 0 = bad-frame flag, valid on the tlast beat.
AXIS_USE_READY, 0, 1 = honour m_axis_tready; 0 = s_axis_tready is tied high.
PAUSE_QUANTA_CYCLES, 2, clk cycles per pause quantum (512 bit times); range 1..255.
STAT_WIDTH, 32, statistics counter width.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
s_axis_tdata  input  AXIS_DATA_WIDTH  RX data from MAC; byte 0 in bits [7:0]
s_axis_tkeep  input  AXIS_KEEP_WIDTH  byte enables
s_axis_tvalid  input  1  valid
s_axis_tready  output  1  ready
s_axis_tlast  input  1  end of frame
s_axis_tuser  input  AXIS_USER_WIDTH  user; bit 0 = bad frame
m_axis_tdata  output  AXIS_DATA_WIDTH  data to datapath
m_axis_tkeep  output  AXIS_KEEP_WIDTH  byte enables
m_axis_tvalid  output  1  valid
m_axis_tready  input  1  ready
m_axis_tlast  output  1  end of frame
m_axis_tuser  output  AXIS_USER_WIDTH  user
cfg_ctrl_filter_enable  input  1  1 = detect and drop MAC control frames; 0 = forward all frames
pause_active  output  1  high while the pause timer is non-zero
pause_quanta_remaining  output  16  quanta left in the current pause
stat_rx_ctrl_frames  output  STAT_WIDTH  MAC control frames dropped
stat_rx_pause_frames  output  STAT_WIDTH  valid PAUSE frames applied

Behaviour:
- Reset (rst=0, asynchronous): state=SOF, pause timer=0, prescaler=0, stats=0, pause_active=0, quanta latch=0. Stream outputs are combinational from inputs, so m_axis_tvalid=0 whenever s_axis_tvalid=0.
- Transfer: a beat transfers when s_axis_tvalid && s_axis_tready.
- FSM states: SOF (next beat is a first beat), PASS, DROP.
- Header fields in SOF, big-endian: EtherType = {byte12, byte13}; opcode = {byte14, byte15}; quanta = {byte16, byte17}.
- is_ctrl = cfg_ctrl_filter_enable && EtherType==0x8808. The enable is sampled only on the first beat; changing it mid-frame has no effect on that frame.
- drop_now = (state==SOF && is_ctrl) || state==DROP.
- Datapath, zero latency:
  - m_axis_tdata/tkeep/tlast/tuser = s_axis_*.
  - m_axis_tvalid = s_axis_tvalid && !drop_now.
  - s_axis_tready = AXIS_USE_READY ? (drop_now || m_axis_tready) : 1.
  - Dropped beats are always consumed.
- Transitions, on a transfer:
  - SOF with tlast: stay in SOF (single-beat frame).
  - SOF, not tlast: go to DROP if is_ctrl, else PASS.
  - PASS or DROP with tlast: go to SOF.
  - No transfer: hold state.
- On an is_ctrl first beat, latch is_pause = (opcode==0x0001) and the quanta value. Single-beat frames use the same-beat values directly.
- On the tlast beat of a dropped frame:
  - stat_rx_ctrl_frames += 1.
  - If is_pause && tuser[0]==0: load timer with the latched quanta, clear prescaler, stat_rx_pause_frames += 1.
  - A bad frame (tuser[0]==1) counts as a control frame but is not applied as PAUSE.
- Pause timer:
  - When pause_quanta_remaining != 0, the prescaler counts 0..PAUSE_QUANTA_CYCLES-1.
  - On wrap, the timer decrements by 1.
  - pause_active = (pause_quanta_remaining != 0), registered.
  - A new PAUSE reloads the timer and overrides the current value, including quanta=0, which clears pause on the next cycle.
  - If a reload and a decrement happen in the same cycle, the reload wins.
  - Timer saturates at 0.
- Counters are STAT_WIDTH bits and wrap modulo 2^STAT_WIDTH.
- Reset mid-frame: the FSM returns to SOF. The next accepted beat is parsed as a first beat, so upstream must also be reset or resynchronised.
- Beats in PASS and DROP are never parsed. An EtherType match in a later beat is ignored.

Test Plan:
- Normal frame, EtherType 0x0800, 3 beats, m_axis_tready=1 -> all 3 beats appear on m_axis on the same cycles; stats stay 0; pause_active=0.
- PAUSE frame: EtherType 0x8808, opcode 0x0001, quanta 0x0003, 2 beats, tuser=0, PAUSE_QUANTA_CYCLES=2 -> m_axis_tvalid stays 0 and s_axis_tready=1 on both beats. The cycle after tlast: pause_active=1, remaining=3; remaining then reaches 0 after 6 cycles; both stats = 1.
- Same PAUSE frame with tuser[0]=1 on tlast -> frame dropped; stat_rx_ctrl_frames=1; stat_rx_pause_frames=0; pause_active=0.
- Reload: PAUSE quanta 100, then after 20 cycles PAUSE quanta 0 -> pause_active falls one cycle after the second tlast; stat_rx_pause_frames=2.
- AXIS_USE_READY=1, m_axis_tready toggling 1010, normal frame then control frame (opcode 0x0101) -> normal beats stall with tready; control beats are consumed at one per cycle; stat_rx_ctrl_frames=1, pause unaffected.
- cfg_ctrl_filter_enable=0 with a PAUSE frame -> frame forwarded unchanged; no stat increment; assert rst low mid-frame -> all outputs return to reset values immediately.
